// File: rtl/pcie_phy_pkg.sv
// Purpose: shared PHY symbol constants and the TX scheduler state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcie_phy_pkg;

  // K28.5 comma that opens a SKP ordered set
  localparam logic [7:0] K28_5_COM = 8'hBC;
  // K28.0 skip symbol that follows the comma
  localparam logic [7:0] K28_0_SKP = 8'h1C;
  // D0.0 logical idle
  localparam logic [7:0] D0_0_IDL  = 8'h00;

  typedef enum logic {
    DATA = 1'b0,
    SKP  = 1'b1
  } tx_sched_state_e;

endpackage

// File: rtl/skp_interval_timer.sv
// Purpose: counts symbol times since the last COM and flags a pending SKP ordered set.
// Latency: skp_pending_o rises the cycle after the count reaches SkpInterval-1.
// Backpressure: none; clr_i (COM load) restarts the count and drops the pending flag.
module skp_interval_timer #(
  parameter int unsigned SkpInterval = 1180
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic skp_pending_o
);

  localparam int unsigned       CntW   = $clog2(SkpInterval);
  localparam logic [CntW-1:0]   CntMax = CntW'(SkpInterval - 1);

  logic [CntW-1:0] sym_cnt_q, sym_cnt_d;
  logic            skp_pending_q, skp_pending_d;

  // Saturating symbol counter; pending latches at the terminal count and holds until COM.
  always_comb begin
    sym_cnt_d     = sym_cnt_q;
    skp_pending_d = skp_pending_q;
    if (clr_i) begin
      sym_cnt_d     = '0;
      skp_pending_d = 1'b0;
    end else begin
      if (sym_cnt_q != CntMax) begin
        sym_cnt_d = sym_cnt_q + 1'b1;
      end
      if (sym_cnt_q == CntMax) begin
        skp_pending_d = 1'b1;
      end
    end
  end

  // Counter and pending flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sym_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
    end else begin
      sym_cnt_q     <= sym_cnt_d;
      skp_pending_q <= skp_pending_d;
    end
  end

  assign skp_pending_o = skp_pending_q;

endmodule

// File: rtl/tx_skp_scheduler.sv
// Purpose: picks one symbol per clock for the 8b/10b encoder: data, D0.0 idle, or a COM+SKP ordered set.
// Latency: 1 cycle from handshake to data_o.
// Backpressure: tx_ready_o drops for the whole ordered set; a pending SKP waits for the packet to end.
module tx_skp_scheduler
  import pcie_phy_pkg::*;
#(
  parameter int unsigned SkpInterval = 1180,
  parameter int unsigned SkpCount    = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_is_k_i,
  input  logic       tx_last_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] data_o,
  output logic       is_special_k_o,
  output logic       skp_active_o
);

  // Index of the final SKP symbol in an ordered set (SkpCount is at most 5).
  localparam logic [2:0] SkpLast = 3'(SkpCount - 1);

  tx_sched_state_e state_q, state_d;
  logic            in_packet_q, in_packet_d;
  logic [2:0]      skp_idx_q, skp_idx_d;
  logic [7:0]      data_q, data_d;
  logic            is_k_q, is_k_d;
  logic            skp_active_q, skp_active_d;

  logic            skp_pending;
  logic            com_load;
  logic            hs;

  skp_interval_timer #(
    .SkpInterval (SkpInterval)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_i         (com_load),
    .skp_pending_o (skp_pending)
  );

  // Ready depends on registered state only, never on tx_valid_i.
  assign tx_ready_o = (state_q == DATA) && !(skp_pending && !in_packet_q);
  assign hs         = tx_valid_i && tx_ready_o;

  // Next-state and next-symbol selection; idle D0.0 is the default symbol.
  always_comb begin
    state_d      = state_q;
    in_packet_d  = in_packet_q;
    skp_idx_d    = skp_idx_q;
    data_d       = D0_0_IDL;
    is_k_d       = 1'b0;
    skp_active_d = 1'b0;
    com_load     = 1'b0;

    if (hs) begin
      in_packet_d = !tx_last_i;
    end

    case (state_q)
      DATA: begin
        if (skp_pending && !in_packet_q) begin
          com_load     = 1'b1;
          data_d       = K28_5_COM;
          is_k_d       = 1'b1;
          skp_active_d = 1'b1;
          skp_idx_d    = '0;
          state_d      = SKP;
        end else if (hs) begin
          data_d = tx_data_i;
          is_k_d = tx_is_k_i;
        end
      end
      SKP: begin
        data_d       = K28_0_SKP;
        is_k_d       = 1'b1;
        skp_active_d = 1'b1;
        skp_idx_d    = skp_idx_q + 1'b1;
        if (skp_idx_q == SkpLast) begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = DATA;
      end
    endcase
  end

  // State, packet tracking and output symbol registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DATA;
      in_packet_q  <= 1'b0;
      skp_idx_q    <= '0;
      data_q       <= D0_0_IDL;
      is_k_q       <= 1'b0;
      skp_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_packet_q  <= in_packet_d;
      skp_idx_q    <= skp_idx_d;
      data_q       <= data_d;
      is_k_q       <= is_k_d;
      skp_active_q <= skp_active_d;
    end
  end

  assign data_o         = data_q;
  assign is_special_k_o = is_k_q;
  assign skp_active_o   = skp_active_q;

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// Purpose: directed scoreboard bench for tx_skp_scheduler with SkpInterval=16, SkpCount=3.
// Latency: expects each symbol one cycle after the cycle that decided it.
// Backpressure: expected tx_ready_o is checked alongside every output symbol.
module tb_tx_skp_scheduler;
  import pcie_phy_pkg::*;

  localparam int IV  = 16;
  localparam int CNT = 3;
  localparam int PER = IV + 1;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_is_k_i = 1'b0;
  logic       tx_last_i = 1'b0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] data_o;
  logic       is_special_k_o;
  logic       skp_active_o;

  always #5 clk_i = ~clk_i;

  tx_skp_scheduler #(
    .SkpInterval (IV),
    .SkpCount    (CNT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tx_data_i      (tx_data_i),
    .tx_is_k_i      (tx_is_k_i),
    .tx_last_i      (tx_last_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .data_o         (data_o),
    .is_special_k_o (is_special_k_o),
    .skp_active_o   (skp_active_o)
  );

  // Expected symbol after the edge closing cycle cyc, plus ready for the following cycle.
  typedef struct {
    logic [7:0] dat;
    logic       k;
    logic       skp;
    logic       rdy;
    int         cyc;
    int         scen;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Ready in cycle c when the first COM decision happens in cycle f.
  function automatic logic rdy_at(int c, int f);
    if (c < f) return 1'b1;
    return ((c - f) % PER) > CNT;
  endfunction

  // Idle-line expectation: COM at f, f+17, ... each followed by three SKPs.
  function automatic exp_t idle_exp(int s, int c, int f);
    exp_t e;
    int   m;
    e.dat = D0_0_IDL;
    e.k   = 1'b0;
    e.skp = 1'b0;
    if (c >= f) begin
      m = (c - f) % PER;
      if (m == 0) begin
        e.dat = K28_5_COM;
        e.k   = 1'b1;
        e.skp = 1'b1;
      end else if (m <= CNT) begin
        e.dat = K28_0_SKP;
        e.k   = 1'b1;
        e.skp = 1'b1;
      end
    end
    e.rdy  = rdy_at(c + 1, f);
    e.cyc  = c;
    e.scen = s;
    return e;
  endfunction

  function automatic exp_t data_exp(int s, int c, int f, logic [7:0] d, logic k);
    exp_t e;
    e     = idle_exp(s, c, f);
    e.dat = d;
    e.k   = k;
    e.skp = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the symbol it should produce.
  task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic l, input exp_t e);
    tx_valid_i = v;
    tx_data_i  = d;
    tx_is_k_i  = k;
    tx_last_i  = l;
    sb.push_back(e);
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_step(input int s, input int c, input int f);
    drive(1'b0, 8'hEE, 1'b1, 1'b0, idle_exp(s, c, f));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  // Monitor: one symbol per clock, compared against the queue head.
  always begin : mon
    exp_t e;
    @(posedge clk_i);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (data_o !== e.dat || is_special_k_o !== e.k || skp_active_o !== e.skp || tx_ready_o !== e.rdy) begin
        n_fail++;
        $display("FAIL sym s%0d c%0d: got data=%h k=%b skp=%b rdy=%b, want data=%h k=%b skp=%b rdy=%b",
                 e.scen, e.cyc, data_o, is_special_k_o, skp_active_o, tx_ready_o,
                 e.dat, e.k, e.skp, e.rdy);
      end
    end
  end

  initial begin
    // Scenario 1: reset with valid held high, then single-byte packet 0xA5, then idle SKP cadence.
    tx_valid_i = 1'b1;
    tx_data_i  = 8'hA5;
    tx_is_k_i  = 1'b0;
    tx_last_i  = 1'b1;
    #1 rst_ni = 1'b0;
    @(posedge clk_i);
    #2;
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_k", 32'(is_special_k_o), 32'd0);
    chk("rst_skp", 32'(skp_active_o), 32'd0);
    chk("rst_rdy", 32'(tx_ready_o), 32'd1);
    rst_ni = 1'b1;
    drive(1'b1, 8'hA5, 1'b0, 1'b1, data_exp(1, 0, IV, 8'hA5, 1'b0));
    for (int c = 1; c <= 40; c++) idle_step(1, c, IV);

    // Scenario 2: 40-byte packet holds off the pending SKP until after 0x28.
    do_reset();
    for (int c = 0; c < 40; c++)
      drive(1'b1, 8'(c + 1), 1'b0, (c == 39), data_exp(2, c, 40, 8'(c + 1), 1'b0));
    for (int c = 40; c <= 62; c++) idle_step(2, c, 40);

    // Scenario 3: packet end lands on the terminal count; COM follows directly.
    do_reset();
    for (int c = 0; c <= 12; c++) idle_step(3, c, IV);
    drive(1'b1, 8'h11, 1'b0, 1'b0, data_exp(3, 13, IV, 8'h11, 1'b0));
    drive(1'b1, 8'h22, 1'b0, 1'b0, data_exp(3, 14, IV, 8'h22, 1'b0));
    drive(1'b1, 8'h33, 1'b0, 1'b1, data_exp(3, 15, IV, 8'h33, 1'b0));
    for (int c = 16; c <= 36; c++) idle_step(3, c, IV);

    // Scenario 4: K passthrough and mid-packet starvation while SKP is pending.
    do_reset();
    for (int c = 0; c <= 13; c++) idle_step(4, c, 19);
    drive(1'b1, 8'h40, 1'b0, 1'b0, data_exp(4, 14, 19, 8'h40, 1'b0));
    drive(1'b1, 8'hFB, 1'b1, 1'b0, data_exp(4, 15, 19, 8'hFB, 1'b1));
    drive(1'b0, 8'hEE, 1'b1, 1'b0, idle_exp(4, 16, 19));
    drive(1'b0, 8'hEE, 1'b1, 1'b0, idle_exp(4, 17, 19));
    drive(1'b1, 8'hFD, 1'b1, 1'b1, data_exp(4, 18, 19, 8'hFD, 1'b1));
    for (int c = 19; c <= 40; c++) idle_step(4, c, 19);

    // Scenario 5: reset after COM and one SKP, then a fresh cadence.
    do_reset();
    for (int c = 0; c <= 17; c++) idle_step(5, c, IV);
    rst_ni = 1'b0;
    #1;
    chk("skprst_data", 32'(data_o), 32'h00);
    chk("skprst_k", 32'(is_special_k_o), 32'd0);
    chk("skprst_skp", 32'(skp_active_o), 32'd0);
    chk("skprst_rdy", 32'(tx_ready_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    for (int c = 0; c <= 20; c++) idle_step(5, c, IV);

    repeat (2) @(posedge clk_i);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
